// File: rtl/nn_pkg.sv
// Shared widths and the packed-word record for the accelerator write-back packer.
package nn_pkg;
   localparam int DATA_WIDTH     = 8;
   localparam int DMA_ADDR_WIDTH = 5;
   localparam int WORD_BYTES     = 4;
   localparam int LANE_W         = $clog2(WORD_BYTES);
   localparam int WADDR_W        = DMA_ADDR_WIDTH - LANE_W;

   typedef struct packed {
      logic [WADDR_W-1:0]               addr;
      logic [DATA_WIDTH*WORD_BYTES-1:0] data;
      logic [WORD_BYTES-1:0]            strb;
   } pkd_word_t;
endpackage

// File: rtl/nn_wr_fifo.sv
// Count-based FIFO of packed words; head reads as zero when empty.
module nn_wr_fifo
   import nn_pkg::*;
#(
   parameter type word_t = pkd_word_t,
   parameter int  DEPTH  = 4
) (
   input  logic  i_clk,
   input  logic  i_rst,
   input  logic  i_push,
   input  word_t i_data,
   input  logic  i_pop,
   output word_t o_data,
   output logic  o_full,
   output logic  o_empty,
   output logic  o_drop
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;
   word_t            mem_q [DEPTH];

   assign o_empty = (count_q == '0);
   assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
   assign do_pop  = i_pop && !o_empty;
   // A pop frees the slot being written, so a push into a full FIFO is kept.
   assign do_push = i_push && (!o_full || do_pop);
   assign o_drop  = i_push && o_full && !do_pop;
   assign o_data  = o_empty ? word_t'('0) : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_ptr_q] <= i_data;
   end
endmodule

// File: rtl/nn_wr_pack.sv
// Packs byte writes from the accelerator DMA port into word writes with lane strobes.
module nn_wr_pack #(
   parameter int DATA_WIDTH     = nn_pkg::DATA_WIDTH,
   parameter int DMA_ADDR_WIDTH = nn_pkg::DMA_ADDR_WIDTH,
   parameter int WORD_BYTES     = nn_pkg::WORD_BYTES,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                                        i_clk,
   input  logic                                        i_rst,
   input  logic                                        i_wr_en,
   input  logic [DMA_ADDR_WIDTH-1:0]                   i_wr_addr,
   input  logic [DATA_WIDTH-1:0]                       i_wr_data,
   input  logic                                        i_flush,
   output logic                                        o_mem_wr_valid,
   input  logic                                        i_mem_wr_ready,
   output logic [DMA_ADDR_WIDTH-$clog2(WORD_BYTES)-1:0] o_mem_wr_addr,
   output logic [DATA_WIDTH*WORD_BYTES-1:0]            o_mem_wr_data,
   output logic [WORD_BYTES-1:0]                       o_mem_wr_strb,
   output logic                                        o_overflow,
   output logic                                        o_idle
);
   localparam int LANE_W  = $clog2(WORD_BYTES);
   localparam int WADDR_W = DMA_ADDR_WIDTH - LANE_W;
   localparam int WORD_W  = DATA_WIDTH * WORD_BYTES;

   typedef struct packed {
      logic [WADDR_W-1:0]    addr;
      logic [WORD_W-1:0]     data;
      logic [WORD_BYTES-1:0] strb;
   } word_t;

   word_t               pk_q, pk_d, push_word, head, merged, fresh;
   logic                overflow_q, overflow_d;
   logic                push, fifo_empty, fifo_full, fifo_drop;
   logic [LANE_W-1:0]   lane;
   logic [WADDR_W-1:0]  waddr;
   logic                pk_empty;

   assign lane     = i_wr_addr[LANE_W-1:0];
   assign waddr    = i_wr_addr[DMA_ADDR_WIDTH-1:LANE_W];
   assign pk_empty = (pk_q.strb == '0);

   always_comb begin
      fresh      = word_t'('0);
      fresh.addr = waddr;
      fresh.data[lane*DATA_WIDTH +: DATA_WIDTH] = i_wr_data;
      fresh.strb[lane] = 1'b1;

      merged = pk_q;
      merged.data[lane*DATA_WIDTH +: DATA_WIDTH] = i_wr_data;
      merged.strb[lane] = 1'b1;
      if (pk_empty) merged = fresh;

      pk_d      = pk_q;
      push      = 1'b0;
      push_word = pk_q;
      if (i_wr_en) begin
         // A byte for another word evicts the pack; flush cannot also push it this cycle.
         if (!pk_empty && pk_q.addr != waddr) begin
            push = 1'b1;
            pk_d = fresh;
         end else if (&merged.strb || i_flush) begin
            push      = 1'b1;
            push_word = merged;
            pk_d      = word_t'('0);
         end else begin
            pk_d = merged;
         end
      end else if (i_flush && !pk_empty) begin
         push = 1'b1;
         pk_d = word_t'('0);
      end
   end

   assign overflow_d = overflow_q | fifo_drop;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pk_q       <= word_t'('0);
         overflow_q <= 1'b0;
      end else begin
         pk_q       <= pk_d;
         overflow_q <= overflow_d;
      end
   end

   nn_wr_fifo #(
      .word_t (word_t),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (push),
      .i_data  (push_word),
      .i_pop   (o_mem_wr_valid && i_mem_wr_ready),
      .o_data  (head),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_drop  (fifo_drop)
   );

   assign o_mem_wr_valid = !fifo_empty;
   assign o_mem_wr_addr  = head.addr;
   assign o_mem_wr_data  = head.data;
   assign o_mem_wr_strb  = head.strb;
   assign o_overflow     = overflow_q;
   assign o_idle         = pk_empty && fifo_empty && !i_wr_en;
endmodule

// File: tb/tb_nn_wr_pack.sv
// Directed bench for nn_wr_pack with an expected-word scoreboard drained by a monitor.
module tb_nn_wr_pack;
   import nn_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_wr_en = 1'b0;
   logic [4:0]  i_wr_addr = '0;
   logic [7:0]  i_wr_data = '0;
   logic        i_flush = 1'b0;
   logic        i_mem_wr_ready = 1'b0;
   logic        o_mem_wr_valid;
   logic [2:0]  o_mem_wr_addr;
   logic [31:0] o_mem_wr_data;
   logic [3:0]  o_mem_wr_strb;
   logic        o_overflow;
   logic        o_idle;

   pkd_word_t exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   nn_wr_pack dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_wr_en        (i_wr_en),
      .i_wr_addr      (i_wr_addr),
      .i_wr_data      (i_wr_data),
      .i_flush        (i_flush),
      .o_mem_wr_valid (o_mem_wr_valid),
      .i_mem_wr_ready (i_mem_wr_ready),
      .o_mem_wr_addr  (o_mem_wr_addr),
      .o_mem_wr_data  (o_mem_wr_data),
      .o_mem_wr_strb  (o_mem_wr_strb),
      .o_overflow     (o_overflow),
      .o_idle         (o_idle)
   );

   always #5 i_clk = ~i_clk;

   // Every accepted word must match the oldest outstanding expectation.
   always @(negedge i_clk) begin
      pkd_word_t got;
      pkd_word_t exp;
      if (!i_rst && o_mem_wr_valid && i_mem_wr_ready) begin
         got.addr = o_mem_wr_addr;
         got.data = o_mem_wr_data;
         got.strb = o_mem_wr_strb;
         n_tests++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_word: observed %h expected none", got);
         end
         if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            assert (got === exp) else begin
               n_fail++;
               $error("FAIL word_out: observed %h expected %h", got, exp);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic cycn(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d, input logic fl);
      i_wr_en   = 1'b1;
      i_wr_addr = a;
      i_wr_data = d;
      i_flush   = fl;
      cyc();
      i_wr_en = 1'b0;
      i_flush = 1'b0;
   endtask

   task automatic flush();
      i_flush = 1'b1;
      cyc();
      i_flush = 1'b0;
   endtask

   task automatic expw(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
      pkd_word_t w;
      w.addr = a;
      w.data = d;
      w.strb = s;
      exp_q.push_back(w);
   endtask

   function automatic logic [31:0] fd(input logic [7:0] b);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   task automatic wr_full(input logic [2:0] wa, input logic [7:0] b, input logic rdy_last);
      for (int l = 0; l < 4; l++) begin
         if (l == 3) i_mem_wr_ready = rdy_last;
         wr({wa, 2'(l)}, b + 8'(l), 1'b0);
      end
   endtask

   initial begin
      #1;
      chk("rst_valid", o_mem_wr_valid, 0);
      chk("rst_addr", o_mem_wr_addr, 0);
      chk("rst_data", o_mem_wr_data, 0);
      chk("rst_strb", o_mem_wr_strb, 0);
      chk("rst_ovf", o_overflow, 0);
      chk("rst_idle", o_idle, 1);
      cycn(2);
      i_rst = 1'b0;

      // Four bytes complete a word; valid follows one cycle later.
      i_mem_wr_ready = 1'b1;
      expw(3'd0, 32'h44332211, 4'hF);
      wr(5'd0, 8'h11, 1'b0);
      wr(5'd1, 8'h22, 1'b0);
      wr(5'd2, 8'h33, 1'b0);
      i_wr_en = 1'b1; i_wr_addr = 5'd3; i_wr_data = 8'h44;
      #1;
      chk("s1_valid_before", o_mem_wr_valid, 0);
      cyc();
      i_wr_en = 1'b0;
      chk("s1_valid_latency", o_mem_wr_valid, 1);
      cycn(3);
      chk("s1_idle", o_idle, 1);

      // Address change evicts the partial word, flush pushes the remainder.
      expw(3'd1, 32'h00A6A500, 4'b0110);
      i_wr_en = 1'b1; i_wr_addr = 5'd5; i_wr_data = 8'hA5;
      #1;
      chk("idle_low_on_wr_en", o_idle, 0);
      cyc();
      i_wr_en = 1'b0;
      wr(5'd6, 8'hA6, 1'b0);
      chk("s2_no_push_yet", o_mem_wr_valid, 0);
      wr(5'd9, 8'hA9, 1'b0);
      chk("s2_push_on_addr9", o_mem_wr_valid, 1);
      expw(3'd2, 32'h0000A900, 4'b0010);
      flush();
      cycn(3);

      // Rewritten lane keeps newest byte.
      expw(3'd0, 32'h00BB0000, 4'b0100);
      wr(5'd2, 8'hAA, 1'b0);
      wr(5'd2, 8'hBB, 1'b0);
      flush();
      cycn(3);
      flush();
      cycn(2);
      chk("empty_flush_idle", o_idle, 1);

      // Flush with a byte to the same word merges then pushes.
      expw(3'd3, 32'h00002010, 4'b0011);
      wr(5'd12, 8'h10, 1'b0);
      wr(5'd13, 8'h20, 1'b1);
      cycn(2);
      chk("flush_merge_idle", o_idle, 1);

      // Flush with a byte to another word pushes the old pack, keeps the new byte.
      expw(3'd4, 32'h00000030, 4'b0001);
      wr(5'd16, 8'h30, 1'b0);
      wr(5'd21, 8'h40, 1'b1);
      cycn(2);
      chk("flush_diff_kept", o_idle, 0);
      expw(3'd5, 32'h00004000, 4'b0010);
      flush();
      cycn(2);
      chk("flush_diff_idle", o_idle, 1);

      // Full FIFO with simultaneous push and pop.
      i_mem_wr_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         expw(3'(k), fd(8'h40 + 8'(k * 8)), 4'hF);
         wr_full(3'(k), 8'h40 + 8'(k * 8), 1'b0);
      end
      chk("s4_full_valid", o_mem_wr_valid, 1);
      expw(3'd4, fd(8'h60), 4'hF);
      wr_full(3'd4, 8'h60, 1'b1);
      i_mem_wr_ready = 1'b0;
      chk("s4_no_ovf", o_overflow, 0);
      chk("s4_head_after_pop", o_mem_wr_addr, 1);
      i_mem_wr_ready = 1'b1;
      cycn(7);
      chk("s4_drained", exp_q.size(), 0);
      chk("s4_ovf_still_low", o_overflow, 0);

      // Overflow: fifth word dropped, held words stable.
      i_mem_wr_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         expw(3'(k), fd(8'h80 + 8'(k * 8)), 4'hF);
         wr_full(3'(k), 8'h80 + 8'(k * 8), 1'b0);
      end
      chk("s3_pre_ovf", o_overflow, 0);
      wr_full(3'd4, 8'hC0, 1'b0);
      chk("s3_ovf", o_overflow, 1);
      chk("s3_valid", o_mem_wr_valid, 1);
      chk("s3_head_addr", o_mem_wr_addr, 0);
      cycn(2);
      chk("s3_head_data_stable", o_mem_wr_data, fd(8'h80));
      chk("s3_head_strb_stable", o_mem_wr_strb, 4'hF);
      i_mem_wr_ready = 1'b1;
      cycn(7);
      chk("s3_drained", exp_q.size(), 0);
      chk("s3_ovf_sticky", o_overflow, 1);

      // Asynchronous reset mid-packing with queued words.
      i_mem_wr_ready = 1'b0;
      wr_full(3'd0, 8'hD0, 1'b0);
      wr_full(3'd1, 8'hE0, 1'b0);
      wr(5'd8, 8'h77, 1'b0);
      #2;
      i_rst = 1'b1;
      #1;
      chk("s6_valid", o_mem_wr_valid, 0);
      chk("s6_addr", o_mem_wr_addr, 0);
      chk("s6_data", o_mem_wr_data, 0);
      chk("s6_strb", o_mem_wr_strb, 0);
      chk("s6_ovf", o_overflow, 0);
      chk("s6_idle", o_idle, 1);
      cyc();
      wr(5'd4, 8'h99, 1'b0);
      wr(5'd5, 8'h9A, 1'b0);
      cyc();
      i_rst = 1'b0;
      i_mem_wr_ready = 1'b1;
      cycn(4);
      chk("s6_no_stale_valid", o_mem_wr_valid, 0);
      flush();
      cycn(3);
      chk("s6_idle_after", o_idle, 1);
      chk("s6_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/nn_wr_pack.md
NN_WR_PACK -- requirements
Module: nn_wr_pack

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte width of the accelerator write-back stream.
REQ-002 Parameter DMA_ADDR_WIDTH, default 5, byte-address width of the accelerator write-back stream.
REQ-003 Parameter WORD_BYTES, default 4, bytes per packed output word (power of two).
REQ-004 Parameter FIFO_DEPTH, default 4, packed-word entries buffered (power of two).
REQ-005 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-006 i_rst  input  1  reset, asynchronous, active-high.
REQ-007 i_wr_en  input  1  byte-write strobe from the accelerator's DMA write port; no backpressure.
REQ-008 i_wr_addr  input  DMA_ADDR_WIDTH  byte address of the write.
REQ-009 i_wr_data  input  DATA_WIDTH  byte payload.
REQ-010 i_flush  input  1  one-cycle pulse: push any partially packed word.
REQ-011 o_mem_wr_valid  output  1  FIFO head holds a word.
REQ-012 i_mem_wr_ready  input  1  memory accepts the head word this cycle.
REQ-013 o_mem_wr_addr  output  DMA_ADDR_WIDTH-log2(WORD_BYTES)  word address.
REQ-014 o_mem_wr_data  output  DATA_WIDTH*WORD_BYTES  word data; byte lane k = bits [8k+7:8k].
REQ-015 o_mem_wr_strb  output  WORD_BYTES  per-lane byte enables.
REQ-016 o_overflow  output  1  sticky: a packed word was dropped because the FIFO was full.
REQ-017 o_idle  output  1  pack register empty and FIFO empty.

Function
REQ-018 Lane = i_wr_addr[log2(WORD_BYTES)-1:0]; word address = the remaining upper bits.
REQ-019 The pack register holds word address, data, and strobe; it is empty when strobe == 0.
REQ-020 Byte to empty pack: load its word address, write the lane, set its strobe bit.
REQ-021 Byte to the same word address: merge into its lane; a rewritten lane takes the newest data.
REQ-022 Byte to a different word address: on the same edge, push the old pack and load the byte as a new pack.
REQ-023 If a merge makes the strobe all-ones, push the merged word on that edge and leave the pack empty.
REQ-024 i_flush with a non-empty pack pushes it and empties the pack.
REQ-025 When i_flush and i_wr_en coincide, merge the byte first, then push and empty the pack.
REQ-026 Exception: if that byte targets a different word address, push the old pack and leave the new byte in the pack; at most one push per cycle.
REQ-027 i_flush with an empty pack is a no-op.
REQ-028 Pop occurs when o_mem_wr_valid && i_mem_wr_ready.
REQ-029 Push and pop in the same cycle are both honoured, including when the FIFO is full.
REQ-030 A push when the FIFO is full and no pop occurs is dropped and sets o_overflow until reset.
REQ-031 Push-to-valid latency is 1 cycle: o_mem_wr_valid rises on the edge after the push.
REQ-032 Words leave in push order; o_mem_wr_addr, o_mem_wr_data and o_mem_wr_strb hold stable while valid is high and ready is low.
REQ-033 Output data lanes with strobe 0 read as zero.
REQ-034 o_idle is combinational from state and is low during any cycle in which i_wr_en is high.

Reset
REQ-035 Asserting i_rst, including mid-packing or mid-transfer, immediately clears the pack register, the FIFO pointers, the FIFO count and o_overflow.
REQ-036 Reset values: o_mem_wr_valid=0, o_mem_wr_addr=0, o_mem_wr_data=0, o_mem_wr_strb=0, o_overflow=0, o_idle=1.
REQ-037 Bytes presented during reset are discarded.

Structure
REQ-038 Shared package nn_pkg holds DATA_WIDTH, DMA_ADDR_WIDTH, WORD_BYTES and a packed-word struct {addr, data, strb}.
REQ-039 The FIFO is a sub-module nn_wr_fifo (push/pop/full/empty, count-based, registered storage).
REQ-040 The pack logic stays in nn_wr_pack.

Verification
REQ-041 Scenario: bytes 0x11,0x22,0x33,0x44 to addresses 0..3 on consecutive cycles, ready=1. Expect one word, addr 0, data 0x44332211, strb 4'hF, valid one cycle after the fourth byte.
REQ-042 Scenario: bytes to addresses 5,6 then to address 9. Expect word addr 1, strb 4'b0110, pushed on the address-9 edge; then i_flush yields word addr 2, strb 4'b0010.
REQ-043 Scenario: ready=0, five full words written. Expect four held in order with valid high, o_overflow=1 after the fifth, and the fifth word never emitted.
REQ-044 Scenario: FIFO full, with a push and ready=1 in the same cycle. Expect no overflow, count unchanged, order preserved.
REQ-045 Scenario: address 2 written 0xAA then 0xBB, then flush. Expect data lane 2 = 0xBB, strb 4'b0100.
REQ-046 Scenario: i_rst asserted with a partial pack and two queued words. Expect outputs at reset values asynchronously and o_idle=1, with no stale word emitted after release.
